// File: rtl/midi_message_parser_pkg.sv
// Shared types and constants for the MIDI message parser: MIDI protocol values, note-range
// configuration, and the parser's internal byte-class and FSM state types.
package MIDI;
   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } status_t;

   typedef struct packed {
      status_t    status;
      logic [6:0] note_number;
      logic [6:0] velocity;
   } note_change_t;

   localparam logic [3:0] NOTE_OFF         = 4'h8;
   localparam logic [3:0] NOTE_ON          = 4'h9;
   localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
   localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
   localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
   localparam logic [7:0] SYSEX_START      = 8'hF0;
endpackage

package CONFIG;
   // Playable range of the synth (standard 88-key piano span).
   localparam logic [6:0] NOTE_NUMBER_START = 7'd21;
   localparam logic [6:0] NOTE_NUMBER_END   = 7'd108;
endpackage

package midi_message_parser_pkg;
   typedef enum logic [1:0] {
      CLS_DATA,
      CLS_CHANNEL,
      CLS_SYSTEM,
      CLS_REALTIME
   } byte_class_t;

   typedef enum logic [1:0] {
      IDLE,
      DATA1,
      DATA2,
      SYSEX
   } parser_state_t;
endpackage

// File: rtl/midi_message_parser_if.sv
// Byte-stream input and note / control-change event outputs of the MIDI message parser.
interface midi_message_parser_if;
   import MIDI::*;

   logic [7:0]   midi_byte;
   logic         midi_byte_valid;
   note_change_t note;
   logic         note_ready;
   logic [6:0]   cc_number;
   logic [6:0]   cc_value;
   logic         cc_ready;

   modport master (
      output midi_byte, midi_byte_valid,
      input  note, note_ready, cc_number, cc_value, cc_ready
   );

   modport slave (
      input  midi_byte, midi_byte_valid,
      output note, note_ready, cc_number, cc_value, cc_ready
   );
endinterface

// File: rtl/midi_message_parser_classifier.sv
// Combinational MIDI byte classifier: byte class plus the number of data bytes a channel
// status byte announces.
module midi_byte_classifier
   import MIDI::*;
   import midi_message_parser_pkg::*;
(
   input  logic [7:0]  midiByte_i,
   output byte_class_t byteClass_o,
   output logic [1:0]  dataBytesNeeded_o
);

   always_comb begin
      byteClass_o       = CLS_DATA;
      dataBytesNeeded_o = 2'd0;
      if (!midiByte_i[7]) begin
         byteClass_o = CLS_DATA;
      end else if (midiByte_i >= 8'hF8) begin
         byteClass_o = CLS_REALTIME;
      end else if (midiByte_i >= 8'hF0) begin
         byteClass_o = CLS_SYSTEM;
      end else begin
         byteClass_o       = CLS_CHANNEL;
         dataBytesNeeded_o = (midiByte_i[7:4] == PROGRAM_CHANGE ||
                              midiByte_i[7:4] == CHANNEL_PRESSURE) ? 2'd1 : 2'd2;
      end
   end

endmodule

// File: rtl/midi_message_parser.sv
// MIDI byte stream to note events, with running status and channel filtering.
// Define MIDI_CC_EN to also emit control-change events on the cc_* outputs.
module midi_message_parser
   import MIDI::*;
   import CONFIG::*;
   import midi_message_parser_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
)
(
   input  logic                  clock_50_000_000,
   input  logic                  reset_l,
   midi_message_parser_if.slave  bus
);

   byte_class_t   byteClass;
   logic [1:0]    dataBytesNeeded;

   parser_state_t state_q;
   logic [7:0]    status_q;
   logic          oneDataByte_q;
   logic [6:0]    data1_q;
   note_change_t  note_q;
   note_change_t  note_d;
   logic          noteReady_q;

   logic [3:0]    command;
   logic          channelOk;
   logic          isNote;
   logic          noteInRange;

   midi_byte_classifier u_classifier (
      .midiByte_i        (bus.midi_byte),
      .byteClass_o       (byteClass),
      .dataBytesNeeded_o (dataBytesNeeded)
   );

   assign command     = status_q[7:4];
   assign channelOk   = OMNI || (status_q[3:0] == CHANNEL);
   assign isNote      = (command == NOTE_ON) || (command == NOTE_OFF);
   assign noteInRange = (data1_q >= NOTE_NUMBER_START) && (data1_q <= NOTE_NUMBER_END);

   // A note-on with zero velocity is a note-off; velocity is passed through raw either way.
   always_comb begin
      note_d             = note_q;
      note_d.status      = (command == NOTE_ON && bus.midi_byte[6:0] != 7'd0) ? ON : OFF;
      note_d.note_number = data1_q;
      note_d.velocity    = bus.midi_byte[6:0];
   end

`ifdef MIDI_CC_EN
   logic [6:0] ccNumber_q;
   logic [6:0] ccValue_q;
   logic       ccReady_q;
`endif

   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         state_q       <= IDLE;
         status_q      <= '0;
         oneDataByte_q <= 1'b0;
         data1_q       <= '0;
         note_q        <= '{status: OFF, note_number: 7'd0, velocity: 7'd0};
         noteReady_q   <= 1'b0;
`ifdef MIDI_CC_EN
         ccNumber_q    <= '0;
         ccValue_q     <= '0;
         ccReady_q     <= 1'b0;
`endif
      end else begin
         noteReady_q <= 1'b0;
`ifdef MIDI_CC_EN
         ccReady_q   <= 1'b0;
`endif
         if (bus.midi_byte_valid) begin
            case (byteClass)
               CLS_CHANNEL: begin
                  status_q      <= bus.midi_byte;
                  oneDataByte_q <= (dataBytesNeeded == 2'd1);
                  state_q       <= DATA1;
               end
               CLS_SYSTEM: begin
                  status_q      <= '0;
                  oneDataByte_q <= 1'b0;
                  state_q       <= (bus.midi_byte == SYSEX_START) ? SYSEX : IDLE;
               end
               CLS_DATA: begin
                  case (state_q)
                     DATA1: begin
                        data1_q <= bus.midi_byte[6:0];
                        if (!oneDataByte_q) begin
                           state_q <= DATA2;
                        end
                     end
                     DATA2: begin
                        // Running status: the next data byte opens a new message.
                        state_q <= DATA1;
                        if (channelOk && isNote && noteInRange) begin
                           note_q      <= note_d;
                           noteReady_q <= 1'b1;
                        end
`ifdef MIDI_CC_EN
                        if (channelOk && command == CONTROL_CHANGE) begin
                           ccNumber_q <= data1_q;
                           ccValue_q  <= bus.midi_byte[6:0];
                           ccReady_q  <= 1'b1;
                        end
`endif
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.note       = note_q;
   assign bus.note_ready = noteReady_q;
`ifdef MIDI_CC_EN
   assign bus.cc_number  = ccNumber_q;
   assign bus.cc_value   = ccValue_q;
   assign bus.cc_ready   = ccReady_q;
`else
   assign bus.cc_number  = '0;
   assign bus.cc_value   = '0;
   assign bus.cc_ready   = 1'b0;
`endif

endmodule

// File: tb/tb_midi_message_parser.sv
// Bench for midi_message_parser: a filtered instance (CHANNEL=0) and an OMNI instance share one
// byte stream; outputs are compared against a message-level model, fixed vectors and hand sequences.
module tb_midi_message_parser;
   import MIDI::*;
   import CONFIG::*;

   logic       clk;
   logic       reset_l;
   logic [7:0] tbByte;
   logic       tbValid;

   int checks;
   int failures;

   midi_message_parser_if bus0();
   midi_message_parser_if bus1();

   assign bus0.midi_byte       = tbByte;
   assign bus0.midi_byte_valid = tbValid;
   assign bus1.midi_byte       = tbByte;
   assign bus1.midi_byte_valid = tbValid;

   midi_message_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
      .clock_50_000_000 (clk),
      .reset_l          (reset_l),
      .bus              (bus0.slave)
   );

   midi_message_parser #(.CHANNEL(4'd5), .OMNI(1'b1)) dut1 (
      .clock_50_000_000 (clk),
      .reset_l          (reset_l),
      .bus              (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: running status plus a queue of the data bytes collected so far.
   logic [3:0]   chanCfg [2] = '{4'd0, 4'd5};
   bit           omniCfg [2] = '{1'b0, 1'b1};
   int           runStatus;
   logic [7:0]   dataQ [$];
   note_change_t expNote [2];
   bit           expReady [2];
   logic [6:0]   expCcNum [2];
   logic [6:0]   expCcVal [2];
   bit           expCcReady [2];

   task automatic modelReset();
      runStatus = -1;
      dataQ.delete();
      for (int i = 0; i < 2; i++) begin
         expNote[i]    = '{status: OFF, note_number: 7'd0, velocity: 7'd0};
         expReady[i]   = 1'b0;
         expCcNum[i]   = 7'd0;
         expCcVal[i]   = 7'd0;
         expCcReady[i] = 1'b0;
      end
   endtask

   task automatic modelEmit(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
      int n;
      n = int'(d1);
      for (int i = 0; i < 2; i++) begin
         if (omniCfg[i] || st[3:0] == chanCfg[i]) begin
            if ((st[7:4] == 4'h8 || st[7:4] == 4'h9) &&
                n >= int'(NOTE_NUMBER_START) && n <= int'(NOTE_NUMBER_END)) begin
               expNote[i].status      = (st[7:4] == 4'h9 && d2 != 8'd0) ? ON : OFF;
               expNote[i].note_number = d1[6:0];
               expNote[i].velocity    = d2[6:0];
               expReady[i]            = 1'b1;
            end
`ifdef MIDI_CC_EN
            if (st[7:4] == 4'hB) begin
               expCcNum[i]   = d1[6:0];
               expCcVal[i]   = d2[6:0];
               expCcReady[i] = 1'b1;
            end
`endif
         end
      end
   endtask

   task automatic modelStep(input bit v, input logic [7:0] b);
      logic [7:0] st;
      int need;
      for (int i = 0; i < 2; i++) begin
         expReady[i]   = 1'b0;
         expCcReady[i] = 1'b0;
      end
      if (!v || b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         runStatus = -1;
         dataQ.delete();
      end else if (b >= 8'h80) begin
         runStatus = int'(b);
         dataQ.delete();
      end else if (runStatus >= 0) begin
         st = runStatus[7:0];
         dataQ.push_back(b);
         need = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
         if (dataQ.size() == need) begin
            modelEmit(st, dataQ[0], (need == 2) ? dataQ[1] : 8'd0);
            dataQ.delete();
         end
      end
   endtask

   task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkOne("dut0.note_ready", 32'(bus0.note_ready), 32'(expReady[0]));
      checkOne("dut0.note",       32'(bus0.note),       32'(expNote[0]));
      checkOne("dut0.cc_ready",   32'(bus0.cc_ready),   32'(expCcReady[0]));
      checkOne("dut0.cc_number",  32'(bus0.cc_number),  32'(expCcNum[0]));
      checkOne("dut0.cc_value",   32'(bus0.cc_value),   32'(expCcVal[0]));
      checkOne("dut1.note_ready", 32'(bus1.note_ready), 32'(expReady[1]));
      checkOne("dut1.note",       32'(bus1.note),       32'(expNote[1]));
      checkOne("dut1.cc_ready",   32'(bus1.cc_ready),   32'(expCcReady[1]));
      checkOne("dut1.cc_number",  32'(bus1.cc_number),  32'(expCcNum[1]));
      checkOne("dut1.cc_value",   32'(bus1.cc_value),   32'(expCcVal[1]));
   endtask

   // One clock cycle: drive at the falling edge, sample just after the rising edge.
   task automatic applyStimulus(input bit v, input logic [7:0] b);
      @(negedge clk);
      tbByte  = b;
      tbValid = v;
      @(posedge clk);
      #1;
      modelStep(v, b);
      checkOutput();
   endtask

   typedef struct {
      logic [7:0]  b;
      bit          v;
      bit          r0;
      bit          r1;
      logic [14:0] note0;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] b, input bit v, input bit r0, input bit r1,
                               input bit st, input logic [6:0] nn, input logic [6:0] vel);
      vec_t t;
      t.b = b; t.v = v; t.r0 = r0; t.r1 = r1; t.note0 = {st, nn, vel};
      return t;
   endfunction

   vec_t vecs [$];

   initial begin
      logic [3:0] his [8];
      logic [7:0] b;
      bit         v;
      int         r;

      checks   = 0;
      failures = 0;
      tbByte   = 8'h00;
      tbValid  = 1'b0;
      reset_l  = 1'b1;
      his      = '{4'h8, 4'h9, 4'h9, 4'hB, 4'hC, 4'hD, 4'hA, 4'hE};

      // Expected values for the CHANNEL=0 instance; r1 is note_ready of the OMNI instance.
      vecs.push_back(mk(8'h90,1,0,0,0,7'h00,7'h00)); vecs.push_back(mk(8'h3C,1,0,0,0,7'h00,7'h00));
      vecs.push_back(mk(8'h64,1,1,1,1,7'h3C,7'h64)); vecs.push_back(mk(8'h40,1,0,0,1,7'h3C,7'h64));
      vecs.push_back(mk(8'h50,1,1,1,1,7'h40,7'h50)); vecs.push_back(mk(8'h90,1,0,0,1,7'h40,7'h50));
      vecs.push_back(mk(8'h3C,1,0,0,1,7'h40,7'h50)); vecs.push_back(mk(8'h00,1,1,1,0,7'h3C,7'h00));
      vecs.push_back(mk(8'h80,1,0,0,0,7'h3C,7'h00)); vecs.push_back(mk(8'h3C,1,0,0,0,7'h3C,7'h00));
      vecs.push_back(mk(8'h40,1,1,1,0,7'h3C,7'h40)); vecs.push_back(mk(8'hF7,1,0,0,0,7'h3C,7'h40));
      vecs.push_back(mk(8'h3C,1,0,0,0,7'h3C,7'h40)); vecs.push_back(mk(8'h90,1,0,0,0,7'h3C,7'h40));
      vecs.push_back(mk(8'hF8,1,0,0,0,7'h3C,7'h40)); vecs.push_back(mk(8'h3C,1,0,0,0,7'h3C,7'h40));
      vecs.push_back(mk(8'hFE,1,0,0,0,7'h3C,7'h40)); vecs.push_back(mk(8'h64,1,1,1,1,7'h3C,7'h64));
      vecs.push_back(mk(8'h90,1,0,0,1,7'h3C,7'h64)); vecs.push_back(mk(8'h3C,1,0,0,1,7'h3C,7'h64));
      vecs.push_back(mk(8'hF0,1,0,0,1,7'h3C,7'h64)); vecs.push_back(mk(8'h64,1,0,0,1,7'h3C,7'h64));
      vecs.push_back(mk(8'h3C,1,0,0,1,7'h3C,7'h64)); vecs.push_back(mk(8'h90,1,0,0,1,7'h3C,7'h64));
      vecs.push_back(mk(8'h14,1,0,0,1,7'h3C,7'h64)); vecs.push_back(mk(8'h64,1,0,0,1,7'h3C,7'h64));
      vecs.push_back(mk(8'h15,1,0,0,1,7'h3C,7'h64)); vecs.push_back(mk(8'h64,1,1,1,1,7'h15,7'h64));
      vecs.push_back(mk(8'h6C,1,0,0,1,7'h15,7'h64)); vecs.push_back(mk(8'h01,1,1,1,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h6D,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'h01,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h91,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'h3C,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h64,1,0,1,1,7'h6C,7'h01)); vecs.push_back(mk(8'hC0,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h05,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'hD0,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h05,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'hB0,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h07,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'h7F,1,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h90,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'h3C,0,0,0,1,7'h6C,7'h01));
      vecs.push_back(mk(8'h3C,1,0,0,1,7'h6C,7'h01)); vecs.push_back(mk(8'h64,1,1,1,1,7'h3C,7'h64));

      #1 reset_l = 1'b0;
      #2;
      modelReset();
      checkOutput();
      @(negedge clk);
      @(negedge clk);
      reset_l = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].v, vecs[i].b);
         checkOne($sformatf("vec%0d.ready0", i), 32'(bus0.note_ready), 32'(vecs[i].r0));
         checkOne($sformatf("vec%0d.note0", i),  32'(bus0.note),       32'(vecs[i].note0));
         checkOne($sformatf("vec%0d.ready1", i), 32'(bus1.note_ready), 32'(vecs[i].r1));
      end

      // Reset in the middle of a note-on: outputs clear at once, and the trailing byte is orphaned.
      applyStimulus(1'b1, 8'h90);
      applyStimulus(1'b1, 8'h3C);
      @(negedge clk);
      tbValid = 1'b0;
      reset_l = 1'b0;
      #1;
      modelReset();
      checkOne("midreset.note", 32'(bus0.note), 32'd0);
      checkOutput();
      @(negedge clk);
      reset_l = 1'b1;
      applyStimulus(1'b1, 8'h64);
      checkOne("midreset.no_pulse", 32'(bus0.note_ready), 32'd0);
      applyStimulus(1'b1, 8'h3C);
      checkOne("lone_data.no_pulse", 32'(bus0.note_ready), 32'd0);

      applyStimulus(1'b1, 8'hB0);
      applyStimulus(1'b1, 8'h07);
      applyStimulus(1'b1, 8'h7F);
`ifdef MIDI_CC_EN
      checkOne("cc.ready",  32'(bus0.cc_ready),  32'd1);
      checkOne("cc.number", 32'(bus0.cc_number), 32'd7);
      checkOne("cc.value",  32'(bus0.cc_value),  32'd127);
`else
      checkOne("cc.ready",  32'(bus0.cc_ready),  32'd0);
      checkOne("cc.number", 32'(bus0.cc_number), 32'd0);
      checkOne("cc.value",  32'(bus0.cc_value),  32'd0);
`endif
      applyStimulus(1'b0, 8'h00);
      checkOne("cc.pulse_once", 32'(bus0.cc_ready), 32'd0);

      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         v = 1'b1;
         if (r < 22) begin
            b = {his[$urandom_range(0, 7)], 4'($urandom_range(0, 3))};
         end else if (r < 72) begin
            b = 8'($urandom_range(0, 127));
         end else if (r < 80) begin
            b = 8'($urandom_range(8'hF8, 8'hFF));
         end else if (r < 85) begin
            b = 8'($urandom_range(8'hF0, 8'hF7));
         end else begin
            b = 8'($urandom_range(0, 255));
            v = 1'b0;
         end
         applyStimulus(v, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
